serial_word_deserializer: RTL and testbench
===========================================

// Module: serial_word_deserializer
// PURPOSE
// - Receive end of the rotating shift-register link: rebuilds a WIDTH-bit word from the serial bit
//   presented one per clock (bit[0] of a right-rotating register, so LSB first by default).
// - Sits between the serial link and a word consumer; presents each word with a valid/ready
//   handshake, flags dropped frames, and tolerates restart/abort mid-frame.
// PARAMETERS
// - WIDTH      8  word length in bits; legal range 2..32
// - LSB_FIRST  1  1: k-th received bit -> data_out[k]; 0: k-th received bit -> data_out[WIDTH-1-k]
// PORTS
// - clk          in   1      single clock; all logic on posedge clk
// - rst          in   1      synchronous, active-high reset
// - start        in   1      frame start; ser_in in the same cycle carries bit 0 of the frame
// - ser_in       in   1      serial data bit, sampled every cycle while a frame is in progress
// - out_ready    in   1      consumer accepts data_out when out_valid && out_ready
// - clr_overrun  in   1      clears sticky overrun flag
// - data_out     out  WIDTH  assembled word; stable while out_valid is high
// - out_valid    out  1      word available
// - busy         out  1      frame in progress (state SHIFT)
// - overrun      out  1      sticky: a frame was lost because the previous word was not accepted
// BEHAVIOUR
// - Reset (rst=1 at posedge): state IDLE, data_out=0, out_valid=0, busy=0, overrun=0, bit count=0,
//   shift register=0. Reset mid-frame discards the partial frame; no word is produced.
// - States: IDLE, SHIFT, VALID. out_valid = (state==VALID); busy = (state==SHIFT).
// - IDLE: start=1 -> capture ser_in as bit 0, count=1, go SHIFT. start=0 -> stay, ser_in ignored.
// - SHIFT: each cycle capture ser_in as bit `count`, count++. Edge capturing bit WIDTH-1 copies the
//   full word into data_out and goes VALID. Latency: start cycle = edge 1; out_valid high after
//   edge WIDTH (WIDTH cycles from start to valid).
// - SHIFT with start=1: abort current frame, ser_in becomes bit 0 of a new frame, count=1; the
//   aborted frame is not reported and does not set overrun.
// - VALID: data_out/out_valid held until out_valid && out_ready.
//   - accept, start=0 -> IDLE.
//   - accept, start=1 -> SHIFT with ser_in as bit 0 (zero-bubble back-to-back frames).
//   - no accept, start=1 -> overrun<=1, new frame dropped entirely, stay VALID, data_out unchanged.
// - data_out changes only on the completion edge; shift register is internal and never exposed.
// - overrun: set as above; cleared by clr_overrun=1; if set and clear occur same cycle, set wins.
// - Bit mapping per LSB_FIRST. Counter width $clog2(WIDTH)+1; never exceeds WIDTH.
// - Link compatibility: a parallel-load right-rotate register loaded with W and shifting, with
//   start asserted in the cycle after load, delivers W exactly with LSB_FIRST=1.
// STRUCTURE
// - Package serial_link_pkg: state enum (IDLE/SHIFT/VALID), default WIDTH constant, shared by
//   the serializer and this block.
// - One sub-module: serial_bit_counter (load-to-1 / increment / terminal-count at WIDTH-1);
//   FSM, shift register and output register stay in the top module.
// TESTING
// - Drive 0xA5 LSB first (1,0,1,0,0,1,0,1), start with bit 0, out_ready=1 -> out_valid high after
//   edge 8, data_out=0xA5, one-cycle pulse, back to IDLE.
// - Same frame, LSB_FIRST=0 -> data_out=0xA5 bit-reversed = 0xA5 (palindrome); then 0x01 -> 0x80.
// - out_ready=0 for 5 cycles after completion of 0x3C -> data_out=0x3C, out_valid held; start
//   during hold -> overrun=1, word still 0x3C; clr_overrun -> overrun=0.
// - Frames 0x12 then 0x34 back-to-back, start on the accept cycle -> two words, no idle cycle.
// - start again at bit 4 of a frame, then full 0x5A -> only 0x5A reported, overrun=0.
// - rst at bit 3 of a frame -> all outputs 0 next cycle; following frame 0xFF decodes correctly.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the rotating shift-register serial link.
// Holds the link state encoding and the default word width.
package serial_link_pkg;

  localparam int DefaultWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    VALID
  } linkState_e;

endpackage

// File: rtl/serial_bit_counter.sv
// Bit position counter for a serial frame.
// A load restarts the count at 1 because bit 0 is captured in the load cycle itself.
module serial_bit_counter
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DefaultWidth,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          last_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= CW'(1);
    end else if (inc_i) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_deserializer.sv
// Receive end of the serial link: assembles WIDTH-bit words and hands them to a
// consumer over valid/ready, reporting frames lost to backpressure as a sticky overrun.
module serial_word_deserializer
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = DefaultWidth,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_in,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;

  linkState_e       state_q;
  logic [WIDTH-1:0] shiftReg_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] dataOut_q;
  logic             outValid_q;
  logic             busy_q;
  logic             overrun_q;

  logic [CW-1:0]    bitCount;
  logic             lastBit;
  logic [CW-1:0]    bitIdx;
  logic [CW-1:0]    bitPos;
  logic             accept;
  logic             cntLoad;
  logic             cntInc;

  assign accept  = (state_q == VALID) && out_ready;
  assign cntLoad = start && ((state_q != VALID) || out_ready);
  assign cntInc  = (state_q == SHIFT) && !start;

  serial_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bitCounter (
    .clk    (clk),
    .rst    (rst),
    .load_i (cntLoad),
    .inc_i  (cntInc),
    .count_o(bitCount),
    .last_o (lastBit)
  );

  // A start always begins a fresh word, so stale bits from an aborted frame are cleared.
  always_comb begin
    bitIdx  = start ? '0 : bitCount;
    bitPos  = LSB_FIRST ? bitIdx : (CW'(WIDTH - 1) - bitIdx);
    shift_d = start ? '0 : shiftReg_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (bitPos == CW'(i)) begin
        shift_d[i] = ser_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      dataOut_q  <= '0;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // The clear is applied first so that a same-cycle overrun set overrides it.
      if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            shiftReg_q <= shift_d;
            state_q    <= SHIFT;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          shiftReg_q <= shift_d;
          if (!start && lastBit) begin
            dataOut_q  <= shift_d;
            state_q    <= VALID;
            busy_q     <= 1'b0;
            outValid_q <= 1'b1;
          end
        end
        VALID: begin
          if (accept) begin
            outValid_q <= 1'b0;
            if (start) begin
              shiftReg_q <= shift_d;
              state_q    <= SHIFT;
              busy_q     <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (start) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = dataOut_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench for serial_word_deserializer: one LSB-first and one MSB-first
// instance share the same serial stimulus and are checked against their own expected words.
module tb_serial_word_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       serIn;
  logic       outReady;
  logic       clrOverrun;

  logic [7:0] dataLsb;
  logic       validLsb;
  logic       busyLsb;
  logic       ovrLsb;
  logic [7:0] dataMsb;
  logic       validMsb;
  logic       busyMsb;
  logic       ovrMsb;

  int         total = 0;
  int         bad = 0;
  logic [7:0] lsbQ[$];
  logic [7:0] msbQ[$];

  serial_word_deserializer #(
    .WIDTH    (8),
    .LSB_FIRST(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ser_in     (serIn),
    .out_ready  (outReady),
    .clr_overrun(clrOverrun),
    .data_out   (dataLsb),
    .out_valid  (validLsb),
    .busy       (busyLsb),
    .overrun    (ovrLsb)
  );

  serial_word_deserializer #(
    .WIDTH    (8),
    .LSB_FIRST(1'b0)
  ) dutMsb (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ser_in     (serIn),
    .out_ready  (outReady),
    .clr_overrun(clrOverrun),
    .data_out   (dataMsb),
    .out_valid  (validMsb),
    .busy       (busyMsb),
    .overrun    (ovrMsb)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven and state is inspected.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] reverse8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = w[7-i];
    end
    return r;
  endfunction

  // Drive the first nBits of a frame LSB first; a completed, expected frame is queued for the scoreboard.
  task automatic applyStimulus(input logic [7:0] w, input int nBits, input bit expectWord);
    for (int k = 0; k < nBits; k++) begin
      start = (k == 0);
      serIn = w[k];
      tick();
    end
    start = 1'b0;
    serIn = 1'b0;
    if (expectWord) begin
      lsbQ.push_back(w);
      msbQ.push_back(reverse8(w));
    end
  endtask

  // Every handshake the consumer sees must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (validLsb && outReady) begin
      checkOutput("wordQueued", lsbQ.size(), 1);
      if (lsbQ.size() > 0) begin
        checkOutput("lsbWord", {24'd0, dataLsb}, {24'd0, lsbQ.pop_front()});
        checkOutput("msbWord", {24'd0, dataMsb}, {24'd0, msbQ.pop_front()});
      end
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    serIn      = 1'b0;
    outReady   = 1'b1;
    clrOverrun = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rstData", {24'd0, dataLsb}, 32'h0);
    checkOutput("rstValid", validLsb, 0);
    checkOutput("rstBusy", busyLsb, 0);
    checkOutput("rstOvr", ovrLsb, 0);

    // 0xA5 decodes with a one-cycle valid pulse and returns to idle.
    applyStimulus(8'hA5, 8, 1'b1);
    checkOutput("a5Valid", validLsb, 1);
    checkOutput("a5Busy", busyLsb, 0);
    tick();
    checkOutput("a5Pulse", validLsb, 0);
    checkOutput("a5Idle", busyLsb, 0);

    // 0x01 exposes bit ordering on the MSB-first instance.
    applyStimulus(8'h01, 8, 1'b1);
    checkOutput("x01MsbData", {24'd0, dataMsb}, 32'h80);
    tick();

    // Backpressure hold, dropped frame, overrun set/clear.
    outReady = 1'b0;
    applyStimulus(8'h3C, 8, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("holdValid", validLsb, 1);
      checkOutput("holdData", {24'd0, dataLsb}, 32'h3C);
      tick();
    end
    applyStimulus(8'h77, 8, 1'b0);
    checkOutput("dropOvr", ovrLsb, 1);
    checkOutput("dropData", {24'd0, dataLsb}, 32'h3C);
    checkOutput("dropValid", validLsb, 1);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    checkOutput("clrOvr", ovrLsb, 0);
    clrOverrun = 1'b1;
    start      = 1'b1;
    tick();
    clrOverrun = 1'b0;
    start      = 1'b0;
    checkOutput("setWinsOvr", ovrLsb, 1);
    checkOutput("setWinsData", {24'd0, dataLsb}, 32'h3C);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    checkOutput("clr2Ovr", ovrLsb, 0);
    outReady = 1'b1;
    tick();
    checkOutput("acceptValid", validLsb, 0);

    // Back-to-back frames with start on the accept cycle.
    applyStimulus(8'h12, 8, 1'b1);
    checkOutput("b2bFirstValid", validLsb, 1);
    start = 1'b1;
    serIn = 1'b0;
    tick();
    checkOutput("b2bNoBubble", busyLsb, 1);
    for (int k = 1; k < 8; k++) begin
      start = 1'b0;
      serIn = (8'h34 >> k) & 1'b1;
      tick();
    end
    serIn = 1'b0;
    lsbQ.push_back(8'h34);
    msbQ.push_back(reverse8(8'h34));
    checkOutput("b2bSecondValid", validLsb, 1);
    tick();

    // Restart mid-frame: only the second frame is reported.
    applyStimulus(8'hC3, 4, 1'b0);
    checkOutput("abortBusy", busyLsb, 1);
    applyStimulus(8'h5A, 8, 1'b1);
    checkOutput("abortOvr", ovrLsb, 0);
    checkOutput("abortData", {24'd0, dataLsb}, 32'h5A);
    tick();

    // Reset part-way through a frame, then a clean frame.
    applyStimulus(8'hB6, 3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRstData", {24'd0, dataLsb}, 32'h0);
    checkOutput("midRstValid", validLsb, 0);
    checkOutput("midRstBusy", busyLsb, 0);
    checkOutput("midRstOvr", ovrLsb, 0);
    checkOutput("midRstMsbBusy", busyMsb, 0);
    applyStimulus(8'hFF, 8, 1'b1);
    tick();
    tick();

    checkOutput("queueEmpty", lsbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
